uart_rx: RTL and testbench

- UART receiver. It is the consuming end of the 16x oversampling tick produced by the baud-rate generator.
- It deserialises an asynchronous 8N1 line (LSB first) into parallel bytes and pulses a done strobe per frame.
- It sits between the board pin and the byte-level consumer (FIFO or interface unit). It shares the same clk and the baud-rate generator's tick.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and clock/baud constants.
// Used by the baud-rate generator and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int OVS_DEFAULT = 16;
   localparam int CLK_HZ      = 100_000_000;
   localparam int BAUD        = 19_200;
   localparam int BAUD_DIV    = CLK_HZ / (BAUD * OVS_DEFAULT);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL selects the level presented while in reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver driven by a baud*OVS oversampling tick.
// Define UART_RX_PARITY_EN to add a parity bit and the parity_err output.
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int SB_TICK   = 16,
   parameter int OVS       = uart_pkg::OVS_DEFAULT
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] dout,
   output logic                 rx_done_tick,
   output logic                 frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   import uart_pkg::*;

   localparam int SMAX = (SB_TICK > OVS) ? SB_TICK : OVS;
   localparam int SW   = $clog2(SMAX);
   localparam int NW   = $clog2(DATA_BITS);

   localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

   state_t               state;
   logic [SW-1:0]        s;
   logic [NW-1:0]        n;
   logic [DATA_BITS-1:0] b;
   logic                 rx_s;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
`endif

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rx),
      .q    (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit      <= 1'b0;
         parity_err   <= 1'b0;
`endif
      end else begin
         rx_done_tick <= 1'b0;
         unique case (state)
            // start detection runs every clk, not only on tick
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (s == S_MID) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (s == S_BIT) begin
                     s <= '0;
                     b <= {rx_s, b[DATA_BITS-1:1]};
                     if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (s == S_BIT) begin
                     s       <= '0;
                     par_bit <= rx_s;
                     state   <= STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (s == S_STOP) begin
                     state        <= IDLE;
                     dout         <= b;
                     frame_err    <= ~rx_s;
                     rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err   <= (^{b, par_bit}) ^ PARITY_ODD;
`endif
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames built from bit lists,
// strobes logged by a monitor and compared against expected bytes.
module tb_uart_rx;

   localparam int TP  = 6;
   localparam int OVS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int FBITS = 11;
   localparam bit PODD  = 1'b0;
`else
   localparam int FBITS = 10;
   localparam bit PODD  = 1'b0;
`endif
   localparam int LAT = FBITS * OVS - OVS / 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick  = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       frame_err;
   logic       parity_err;

   int checks = 0;
   int errors = 0;
   int tick_now = 0;
   int start_tick = 0;
   logic prev_done = 1'b0;

   logic [7:0] got_d[$];
   logic       got_e[$];
   logic       got_p[$];
   int         got_t[$];

   uart_rx #(
      .DATA_BITS(8),
      .SB_TICK  (16),
      .OVS      (OVS)
`ifdef UART_RX_PARITY_EN
      ,
      .PARITY_ODD(PODD)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .rx          (rx),
      .dout        (dout),
      .rx_done_tick(rx_done_tick),
      .frame_err   (frame_err)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err  (parity_err)
`endif
   );

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (TP - 1) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   always @(posedge clk) if (tick) tick_now <= tick_now + 1;

   always @(negedge clk) begin
      if (rx_done_tick) begin
         checks++;
         if (prev_done) begin
            errors++;
            $display("FAIL single_strobe: strobe high on two consecutive clks");
         end
         got_d.push_back(dout);
         got_e.push_back(frame_err);
         got_p.push_back(parity_err);
         got_t.push_back(tick_now);
      end
      prev_done = rx_done_tick;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic wait_ticks(input int k);
      repeat (k) begin
         do @(posedge clk); while (!tick);
         @(negedge clk);
      end
   endtask

   task automatic clear_log();
      got_d.delete();
      got_e.delete();
      got_p.delete();
      got_t.delete();
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return (^d) ^ PODD;
   endfunction

   // One frame at exactly OVS ticks per bit; a bad stop bit is low only
   // across its sample point so the line is idle again before the next frame.
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input logic par);
      start_tick = tick_now;
      rx = 1'b0;
      wait_ticks(OVS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_ticks(OVS);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      wait_ticks(OVS);
`else
      if (par === 1'bx) rx = 1'b1;
`endif
      if (stop) begin
         rx = 1'b1;
         wait_ticks(OVS);
      end else begin
         rx = 1'b0;
         wait_ticks(10);
         rx = 1'b1;
         wait_ticks(OVS - 10);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_dout: got %h want 00", dout);
      end
      checks++;
      if (rx_done_tick !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: done %b ferr %b want 0 0",
                  rx_done_tick, frame_err);
      end
      checks++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_perr: got %b want 0", parity_err);
      end
      rst_n = 1'b1;
      wait_ticks(4);
      checks++;
      if (dout !== 8'h00 || rx_done_tick !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: dout %h done %b want 00 0",
                  dout, rx_done_tick);
      end
   endtask

   task automatic test_basic();
      clear_log();
      send_frame(8'h55, 1'b1, good_par(8'h55));
      wait_ticks(8);
      checks++;
      if (got_d.size() != 1) begin
         errors++;
         $display("FAIL basic_count: got %0d strobes want 1", got_d.size());
      end
      if (got_d.size() >= 1) begin
         checks++;
         if (got_d[0] !== 8'h55 || got_e[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_data: got %h/%b want 55/0", got_d[0], got_e[0]);
         end
         checks++;
         if (got_t[0] - start_tick < LAT - 1 || got_t[0] - start_tick > LAT + 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d ticks want %0d",
                     got_t[0] - start_tick, LAT);
         end
      end
   endtask

   task automatic test_glitch();
      clear_log();
      rx = 1'b0;
      wait_ticks(4);
      rx = 1'b1;
      wait_ticks(40);
      checks++;
      if (got_d.size() != 0 || dout !== 8'h55) begin
         errors++;
         $display("FAIL glitch: got %0d strobes dout %h want 0 strobes dout 55",
                  got_d.size(), dout);
      end
   endtask

   task automatic test_frame_err();
      clear_log();
      send_frame(8'hA3, 1'b0, good_par(8'hA3));
      send_frame(8'h3C, 1'b1, good_par(8'h3C));
      wait_ticks(8);
      checks++;
      if (got_d.size() != 2) begin
         errors++;
         $display("FAIL ferr_count: got %0d strobes want 2", got_d.size());
      end else begin
         checks++;
         if (got_d[0] !== 8'hA3 || got_e[0] !== 1'b1) begin
            errors++;
            $display("FAIL ferr_bad: got %h/%b want a3/1", got_d[0], got_e[0]);
         end
         checks++;
         if (got_d[1] !== 8'h3C || got_e[1] !== 1'b0) begin
            errors++;
            $display("FAIL ferr_clean: got %h/%b want 3c/0", got_d[1], got_e[1]);
         end
      end
   endtask

   task automatic test_break();
      int cnt;
      int bad;
      clear_log();
      rx = 1'b0;
      wait_ticks(500);
      cnt = got_d.size();
      rx = 1'b1;
      bad = 0;
      for (int i = 0; i < cnt; i++)
         if (got_d[i] !== 8'h00 || got_e[i] !== 1'b1) bad++;
      checks++;
      if (cnt < 2 || bad != 0) begin
         errors++;
         $display("FAIL break: got %0d strobes %0d bad want >=2 strobes 0 bad",
                  cnt, bad);
      end
      wait_ticks(200);
      clear_log();
   endtask

   task automatic test_back_to_back();
      clear_log();
      send_frame(8'h00, 1'b1, good_par(8'h00));
      send_frame(8'hFF, 1'b1, good_par(8'hFF));
      wait_ticks(8);
      checks++;
      if (got_d.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d strobes want 2", got_d.size());
      end else begin
         checks++;
         if (got_d[0] !== 8'h00 || got_d[1] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_data: got %h %h want 00 ff", got_d[0], got_d[1]);
         end
         checks++;
         if (got_t[1] - got_t[0] != FBITS * OVS) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d ticks want %0d",
                     got_t[1] - got_t[0], FBITS * OVS);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'h81;
      clear_log();
      rx = 1'b0;
      wait_ticks(OVS);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         wait_ticks(OVS);
      end
      rx = d[4];
      wait_ticks(8);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rx = 1'b1;
      checks++;
      if (got_d.size() != 0 || dout !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_abort: got %0d strobes dout %h want 0 00",
                  got_d.size(), dout);
      end
      wait_ticks(40);
      send_frame(8'h7E, 1'b1, good_par(8'h7E));
      wait_ticks(8);
      checks++;
      if (got_d.size() != 1 || dout !== 8'h7E) begin
         errors++;
         $display("FAIL rst_mid_next: got %0d strobes dout %h want 1 7e",
                  got_d.size(), dout);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_d[$];
      logic       exp_e[$];
      logic       exp_p[$];
      logic [7:0] d;
      logic       st;
      logic       p;
      clear_log();
      for (int i = 0; i < 12; i++) begin
         d  = 8'($urandom);
         st = ($urandom_range(0, 3) != 0);
         p  = 1'($urandom);
         exp_d.push_back(d);
         exp_e.push_back(~st);
`ifdef UART_RX_PARITY_EN
         exp_p.push_back(p != good_par(d));
`else
         exp_p.push_back(1'b0);
`endif
         send_frame(d, st, p);
         wait_ticks($urandom_range(0, 20));
      end
      wait_ticks(8);
      checks++;
      if (got_d.size() != exp_d.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d strobes want %0d",
                  got_d.size(), exp_d.size());
      end else begin
         for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] ||
                got_p[i] !== exp_p[i]) begin
               errors++;
               $display("FAIL rand_frame%0d: got %h/%b/%b want %h/%b/%b", i,
                        got_d[i], got_e[i], got_p[i],
                        exp_d[i], exp_e[i], exp_p[i]);
            end
         end
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      clear_log();
      send_frame(8'h07, 1'b1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b0);
      wait_ticks(8);
      checks++;
      if (got_d.size() != 2) begin
         errors++;
         $display("FAIL par_count: got %0d strobes want 2", got_d.size());
      end else begin
         checks++;
         if (got_p[0] !== 1'b0 || got_d[0] !== 8'h07) begin
            errors++;
            $display("FAIL par_good: got %h/%b want 07/0", got_d[0], got_p[0]);
         end
         checks++;
         if (got_p[1] !== 1'b1 || got_d[1] !== 8'h07) begin
            errors++;
            $display("FAIL par_bad: got %h/%b want 07/1", got_d[1], got_p[1]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_break();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
